sram_ctrl: RTL

//  Clocked, parametrised controller for an external asynchronous SRAM (DE2-class IS61LV25616).

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_ctrl_if.sv | 27 ++
 rtl/sram_ctrl_dq_io.sv | 33 +++
 rtl/sram_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: one-hot FSM encoding, wait-counter sizing and state helpers
// shared by the asynchronous SRAM controller files.
package sram_ctrl_pkg;

  localparam int WAIT_W   = 4;
  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    RD_ACC   = 6'b000010,
    RD_TURN  = 6'b000100,
    WR_SETUP = 6'b001000,
    WR_PULSE = 6'b010000,
    WR_HOLD  = 6'b100000
  } stateT;

  // States in which the chip is selected and the held byte lanes are presented.
  function automatic logic isChipActive(input stateT s);
    return (s == RD_ACC) || (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: single-word valid/ready host port of the SRAM controller.
interface sram_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
);
  localparam int NB = DATA_W / 8;

  logic              iREQ;
  logic              iWR;
  logic [ADDR_W-1:0] iADDR;
  logic [DATA_W-1:0] iDATA;
  logic [NB-1:0]     iBE_N;
  logic              oREADY;
  logic [DATA_W-1:0] oRDATA;
  logic              oRVALID;

  modport master (
    output iREQ, iWR, iADDR, iDATA, iBE_N,
    input  oREADY, oRDATA, oRVALID
  );

  modport slave (
    input  iREQ, iWR, iADDR, iDATA, iBE_N,
    output oREADY, oRDATA, oRVALID
  );

endinterface

// File: rtl/sram_ctrl_dq_io.sv
// sram_ctrl_dq_io: registered tri-state driver and input sample register for a
// bidirectional memory data bus; kept generic so other memory wrappers can reuse it.
module sram_ctrl_dq_io #(
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              oeNext,
  input  logic              loadData,
  input  logic [DATA_W-1:0] dataNext,
  input  logic              capture,
  output logic [DATA_W-1:0] sampleData,
  inout  wire  [DATA_W-1:0] dq
);
  logic              oeReg;
  logic [DATA_W-1:0] outReg;

  // Enable and data are both flops so the pad never sees decode glitches.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oeReg      <= 1'b0;
      outReg     <= '0;
      sampleData <= '0;
    end else begin
      oeReg <= oeNext;
      if (loadData) outReg <= dataNext;
      if (capture) sampleData <= dq;
    end
  end

  assign dq = oeReg ? outReg : 'z;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-word valid/ready host requests into timed CE_N/OE_N/WE_N
// cycles for an external asynchronous SRAM, with wait states and byte lanes.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  sram_ctrl_if.slave          host,
  inout  wire  [DATA_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic [DATA_W/8-1:0] SRAM_BE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N
);
  localparam int NB = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : gBadDataWidth
    $error("sram_ctrl: DATA_W must be a non-zero multiple of 8");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : gBadWaitCycles
    $error("sram_ctrl: WAIT_CYCLES must lie in 0..15");
  end

  stateT             state;
  stateT             nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic              waitDone;
  logic              accept;
  logic              capture;
  logic              loadWrData;
  logic [ADDR_W-1:0] holdAddr;
  logic [NB-1:0]     holdBeN;
  logic [DATA_W-1:0] rdMask;
  logic [DATA_W-1:0] sampleData;
  logic              rvalidReg;
  logic              ceNNext;
  logic              oeNNext;
  logic              weNNext;
  logic              dqOeNext;
  logic              rvalidNext;
  logic [NB-1:0]     beNNext;

  function automatic logic [DATA_W-1:0] laneMask(input logic [NB-1:0] beN);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) m[b*8 +: 8] = {8{~beN[b]}};
    return m;
  endfunction

  assign waitDone    = (waitCnt == '0);
  assign accept      = host.iREQ && (state == IDLE);
  assign loadWrData  = accept && host.iWR;
  assign capture     = (state == RD_ACC) && waitDone;
  assign host.oREADY = (state == IDLE);
  assign host.oRVALID = rvalidReg;
  assign host.oRDATA = sampleData & rdMask;
  assign SRAM_ADDR   = holdAddr;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (host.iREQ) nextState = host.iWR ? WR_SETUP : RD_ACC;
      RD_ACC:   if (waitDone) nextState = RD_TURN;
      RD_TURN:  nextState = IDLE;
      WR_SETUP: nextState = WR_PULSE;
      WR_PULSE: if (waitDone) nextState = WR_HOLD;
      WR_HOLD:  nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered, then registered below.
  always_comb begin
    ceNNext    = ~isChipActive(nextState);
    oeNNext    = (nextState != RD_ACC);
    weNNext    = (nextState != WR_PULSE);
    dqOeNext   = (nextState == WR_PULSE) || (nextState == WR_HOLD);
    rvalidNext = (nextState == RD_TURN);
    beNNext    = '1;
    if (isChipActive(nextState)) beNNext = accept ? host.iBE_N : holdBeN;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_BE_N <= '1;
      rvalidReg <= 1'b0;
    end else begin
      SRAM_CE_N <= ceNNext;
      SRAM_OE_N <= oeNNext;
      SRAM_WE_N <= weNNext;
      SRAM_BE_N <= beNNext;
      rvalidReg <= rvalidNext;
    end
  end

  // The counter saturates at zero; it is reloaded on every entry to an access window.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      waitCnt <= '0;
    end else if ((nextState == RD_ACC && state != RD_ACC) ||
                 (nextState == WR_PULSE && state != WR_PULSE)) begin
      waitCnt <= WAIT_W'(WAIT_CYCLES);
    end else if (!waitDone) begin
      waitCnt <= waitCnt - WAIT_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      holdAddr <= '0;
      holdBeN  <= '1;
      rdMask   <= '0;
    end else begin
      if (accept) begin
        holdAddr <= host.iADDR;
        holdBeN  <= host.iBE_N;
      end
      if (capture) rdMask <= laneMask(holdBeN);
    end
  end

  sram_ctrl_dq_io #(
    .DATA_W(DATA_W)
  ) dqIo (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .oeNext    (dqOeNext),
    .loadData  (loadWrData),
    .dataNext  (host.iDATA),
    .capture   (capture),
    .sampleData(sampleData),
    .dq        (SRAM_DQ)
  );

endmodule
